// File: rtl/crc_accel_pkg.sv
// Shared definitions for the CRC-32 accelerator: register map, STATUS layout,
// engine states and the byte-wide CRC update.
package crc_accel_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd2;
    localparam logic [2:0] REG_RESULT = 3'd3;
    localparam logic [2:0] REG_SEED   = 3'd4;
    localparam logic [2:0] REG_BYTES  = 3'd5;

    localparam int unsigned STAT_BUSY  = 0;
    localparam int unsigned STAT_FULL  = 1;
    localparam int unsigned STAT_EMPTY = 2;
    localparam int unsigned STAT_ERR   = 3;
    localparam int unsigned STAT_CNT_LSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PROC = 1'b1
    } state_t;

    // Reflected CRC, data bits consumed LSB first.
    function automatic logic [31:0] crc8(input logic [31:0] crc_in,
                                         input logic [7:0]  data,
                                         input logic [31:0] poly);
        logic [31:0] c;
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (poly & {32{c[0] ^ data[i]}});
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush; push ignored when full,
// pop ignored when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/crc_accel.sv
// Memory-mapped CRC-32 accelerator: bus register file, input word FIFO and a
// byte-serial CRC engine.
module crc_accel
    import crc_accel_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] POLY       = 32'hEDB88320,
    parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
    parameter logic [31:0] SEED_RESET = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t      state;
    state_t      next_state;
    logic [31:0] crc;
    logic [31:0] seed;
    logic [31:0] bytes;
    logic        err;
    logic [31:0] word;
    logic [1:0]  last;
    logic [1:0]  idx;

    logic [33:0] fifo_din;
    logic [33:0] fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;

    logic        hit;
    logic        is_write;
    logic [2:0]  reg_idx;
    logic        data_wr;
    logic        strobe_ok;
    logic [1:0]  n_minus_1;
    logic        result_rd;
    logic        stall;
    logic        push;
    logic        pop;
    logic        start;
    logic        bad_strobe;
    logic        seed_wr;
    logic [7:0]  cur_byte;
    logic        unused_addr_bits;

    assign hit      = valid && (addr[7:5] == 3'd0);
    assign is_write = |wstrb;
    assign reg_idx  = addr[4:2];
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        strobe_ok = 1'b1;
        n_minus_1 = 2'd0;
        case (wstrb)
            4'b0001: n_minus_1 = 2'd0;
            4'b0011: n_minus_1 = 2'd1;
            4'b0111: n_minus_1 = 2'd2;
            4'b1111: n_minus_1 = 2'd3;
            default: strobe_ok = 1'b0;
        endcase
    end

    assign data_wr    = hit && is_write && (reg_idx == REG_DATA);
    assign result_rd  = hit && !is_write && (reg_idx == REG_RESULT);
    assign start      = hit && is_write && (reg_idx == REG_CTRL) && wdata[0];
    assign seed_wr    = hit && is_write && (reg_idx == REG_SEED);
    assign bad_strobe = data_wr && !strobe_ok;
    assign push       = data_wr && strobe_ok && !fifo_full;
    assign fifo_din   = {n_minus_1, wdata};

    // Malformed DATA strobes never push, so they are never held off by FULL.
    assign stall = (data_wr && strobe_ok && fifo_full) ||
                   (result_rd && (!fifo_empty || state != ST_IDLE));
    assign ready = valid && !stall;

    sync_fifo #(
        .WIDTH (34),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (start),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_PROC;
                end
            end
            ST_PROC: begin
                if (idx == last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (start) begin
            pop        = 1'b0;
            next_state = ST_IDLE;
        end
    end

    assign cur_byte = word[{idx, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            crc   <= SEED_RESET;
            seed  <= SEED_RESET;
            bytes <= '0;
            err   <= 1'b0;
            word  <= '0;
            last  <= '0;
            idx   <= '0;
        end else begin
            if (seed_wr) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (wstrb[i]) seed[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            if (start) begin
                crc   <= seed;
                bytes <= '0;
                err   <= 1'b0;
                idx   <= '0;
            end else begin
                if (bad_strobe) err <= 1'b1;
                if (pop) begin
                    word <= fifo_dout[31:0];
                    last <= fifo_dout[33:32];
                    idx  <= '0;
                end
                if (state == ST_PROC) begin
                    crc   <= crc8(crc, cur_byte, POLY);
                    bytes <= bytes + 32'd1;
                    idx   <= idx + 2'd1;
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (hit && !is_write) begin
            case (reg_idx)
                REG_STATUS: begin
                    rdata[STAT_BUSY]  = (state != ST_IDLE) || !fifo_empty;
                    rdata[STAT_FULL]  = fifo_full;
                    rdata[STAT_EMPTY] = fifo_empty;
                    rdata[STAT_ERR]   = err;
                    rdata[STAT_CNT_LSB +: 4] = 4'(fifo_count);
                end
                REG_RESULT: rdata = crc ^ XOROUT;
                REG_SEED:   rdata = seed;
                REG_BYTES:  rdata = bytes;
                default:    rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_accel.sv
// Directed self-checking bench for crc_accel: bus accesses with hand-derived
// expected register values and stall behaviour.
module tb_crc_accel;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_DATA   = 8'h08;
    localparam logic [7:0] A_RESULT = 8'h0C;
    localparam logic [7:0] A_SEED   = 8'h10;
    localparam logic [7:0] A_BYTES  = 8'h14;

    always #5 clk = ~clk;

    crc_accel #(
        .FIFO_DEPTH (4),
        .POLY       (32'hEDB88320),
        .XOROUT     (32'hFFFFFFFF),
        .SEED_RESET (32'hFFFFFFFF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .addr  (addr),
        .wdata (wdata),
        .wstrb (wstrb),
        .rdata (rdata),
        .ready (ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the access completes.
    task automatic bus(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output int unsigned stalls);
        bit timed_out;
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        stalls = 0; timed_out = 1'b0;
        #1;
        while (!ready && !timed_out) begin
            @(negedge clk);
            #1;
            stalls++;
            if (stalls > 200) timed_out = 1'b1;
        end
        rd = rdata;
        if (timed_out) check_eq("bus_timeout", 32'd1, 32'd0);
        @(negedge clk);
        valid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int unsigned stalls);
        logic [31:0] rd;
        bus(a, d, s, rd, stalls);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [31:0] rd, output int unsigned stalls);
        bus(a, 32'h0, 4'h0, rd, stalls);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int unsigned st;
        int unsigned total_stalls;

        rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        @(negedge clk);
        do_reset();

        // 1: reset state
        rd_reg(A_STATUS, r, st);
        check_eq("rst_status", r, 32'h00000004);
        check_eq("rst_status_stall", st, 0);
        rd_reg(A_RESULT, r, st);
        check_eq("rst_result", r, 32'h00000000);
        check_eq("rst_result_stall", st, 0);
        rd_reg(A_SEED, r, st);
        check_eq("rst_seed", r, 32'hFFFFFFFF);

        // 2: "123456789" -> standard CRC-32 check value
        wr(A_CTRL, 32'h1, 4'hF, st);
        wr(A_DATA, 32'h34333231, 4'hF, st);
        wr(A_DATA, 32'h38373635, 4'hF, st);
        wr(A_DATA, 32'h00000039, 4'h1, st);
        rd_reg(A_RESULT, r, st);
        check_eq("check_result", r, 32'hCBF43926);
        check_eq("check_result_stalled", 32'(st != 0), 32'd1);
        rd_reg(A_BYTES, r, st);
        check_eq("check_bytes", r, 32'd9);
        rd_reg(A_STATUS, r, st);
        check_eq("check_status_idle", r, 32'h00000004);
        rd_reg(A_CTRL, r, st);
        check_eq("ctrl_reads_zero", r, 32'h0);

        // 3: back-pressure; the 6th write meets a full FIFO
        wr(A_CTRL, 32'h1, 4'hF, st);
        total_stalls = 0;
        for (int i = 0; i < 6; i++) begin
            wr(A_DATA, 32'hFFFFFFFF, 4'hF, st);
            if (i < 5) check_eq("bp_early_stall", st, 0);
            total_stalls += st;
        end
        check_eq("bp_stalled", 32'(total_stalls != 0), 32'd1);
        rd_reg(A_STATUS, r, st);
        check_eq("bp_status_full", r, 32'h00000043);
        rd_reg(A_RESULT, r, st);
        rd_reg(A_BYTES, r, st);
        check_eq("bp_bytes", r, 32'd24);

        // 4: malformed strobe sets sticky ERR without stalling or pushing
        wr(A_DATA, 32'h12345678, 4'b0101, st);
        check_eq("err_no_stall", st, 0);
        rd_reg(A_STATUS, r, st);
        check_eq("err_status", r, 32'h0000000C);
        wr(A_CTRL, 32'h1, 4'hF, st);
        rd_reg(A_STATUS, r, st);
        check_eq("err_cleared", r, 32'h00000004);

        // 5: START aborts in-flight work
        wr(A_CTRL, 32'h1, 4'hF, st);
        wr(A_DATA, 32'h11111111, 4'hF, st);
        wr(A_DATA, 32'h22222222, 4'hF, st);
        wr(A_DATA, 32'h33333333, 4'hF, st);
        wr(A_CTRL, 32'h1, 4'hF, st);
        rd_reg(A_STATUS, r, st);
        check_eq("abort_status", r, 32'h00000004);
        rd_reg(A_RESULT, r, st);
        check_eq("abort_result", r, 32'h00000000);
        check_eq("abort_result_stall", st, 0);
        rd_reg(A_BYTES, r, st);
        check_eq("abort_bytes", r, 32'd0);

        // 6: zero seed, one zero byte: crc stays 0, result is XOROUT
        wr(A_SEED, 32'h00000000, 4'hF, st);
        wr(A_CTRL, 32'h1, 4'hF, st);
        wr(A_DATA, 32'h00000000, 4'h1, st);
        rd_reg(A_RESULT, r, st);
        check_eq("seed0_result", r, 32'hFFFFFFFF);
        rd_reg(A_SEED, r, st);
        check_eq("seed0_readback", r, 32'h00000000);
        rd_reg(A_BYTES, r, st);
        check_eq("seed0_bytes", r, 32'd1);

        // unmapped offset reads zero
        rd_reg(8'h18, r, st);
        check_eq("unmapped_read", r, 32'h0);
        check_eq("unmapped_stall", st, 0);

        // reset mid-word restores everything
        wr(A_SEED, 32'hDEADBEEF, 4'hF, st);
        wr(A_CTRL, 32'h1, 4'hF, st);
        wr(A_DATA, 32'hA5A5A5A5, 4'hF, st);
        @(negedge clk);
        do_reset();
        rd_reg(A_STATUS, r, st);
        check_eq("rst2_status", r, 32'h00000004);
        rd_reg(A_RESULT, r, st);
        check_eq("rst2_result", r, 32'h00000000);
        rd_reg(A_BYTES, r, st);
        check_eq("rst2_bytes", r, 32'd0);
        rd_reg(A_SEED, r, st);
        check_eq("rst2_seed", r, 32'hFFFFFFFF);

        // standard CRC-32 of a single 0x00 byte
        wr(A_CTRL, 32'h1, 4'hF, st);
        wr(A_DATA, 32'h00000000, 4'h1, st);
        rd_reg(A_RESULT, r, st);
        check_eq("zero_byte_result", r, 32'hD202EF8D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
